// File: rtl/spi_s2p.sv
// SPI receive shifter: samples data_in when cnt == SAMPLE_PHASE, pushes each word to the RX FIFO one cycle after its last bit.
// Words are MSB first unless SPI_S2P_LSB_FIRST_EN is defined; a word completing while the FIFO is full is dropped and flagged.
module spi_s2p #(
    parameter int         DATAWIDTH    = 8,
    parameter logic [1:0] SAMPLE_PHASE = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s2p_enable,
    input  logic [1:0]           cnt,
    input  logic                 data_in,
    output logic [DATAWIDTH-1:0] wdata0,
    output logic                 wen0,
    input  logic                 not_full0,
    output logic                 byte_done,
    output logic                 overflow,
    input  logic                 overflow_clr
);

    localparam int CW = $clog2(DATAWIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATAWIDTH-1:0] shreg;
    logic [DATAWIDTH-1:0] shifted;
    logic [CW-1:0]        bitcnt;
    logic                 sample;
    logic                 last;
    logic                 do_shift;
    logic                 do_clear;
    logic                 drop;

    assign sample = (cnt == SAMPLE_PHASE);
    assign last   = (bitcnt == CW'(DATAWIDTH - 1));

`ifdef SPI_S2P_LSB_FIRST_EN
    assign shifted = {data_in, shreg[DATAWIDTH-1:1]};
`else
    assign shifted = {shreg[DATAWIDTH-2:0], data_in};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_shift  = 1'b0;
        do_clear  = 1'b0;
        wen0      = 1'b0;
        byte_done = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                // The strobe coinciding with enable is deliberately not captured.
                do_clear = 1'b1;
                if (s2p_enable) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!s2p_enable) begin
                    state_nxt = IDLE;
                    do_clear  = 1'b1;
                end else if (sample) begin
                    do_shift = 1'b1;
                    if (last) begin
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                byte_done = 1'b1;
                wen0      = not_full0;
                drop      = ~not_full0;
                if (s2p_enable) begin
                    state_nxt = SHIFT;
                    do_shift  = sample;
                end else begin
                    state_nxt = IDLE;
                    do_clear  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            bitcnt   <= '0;
            wdata0   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_clear) begin
                shreg  <= '0;
                bitcnt <= '0;
            end else if (do_shift) begin
                shreg  <= shifted;
                bitcnt <= last ? '0 : bitcnt + CW'(1);
                if (last) begin
                    wdata0 <= shifted;
                end
            end
            // A drop in the same cycle as a clear request keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_s2p.sv
// Bench for spi_s2p: directed word table plus randomized traffic against a bit-list reference model.
module tb_spi_s2p;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s2p_enable = 1'b0;
    logic [1:0]    cnt = 2'd0;
    logic          data_in = 1'b0;
    logic [DW-1:0] wdata0;
    logic          wen0;
    logic          not_full0 = 1'b1;
    logic          byte_done;
    logic          overflow;
    logic          overflow_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: number of bits gathered, their value, pending write slot
    logic          m_run = 1'b0;
    int            m_n = 0;
    int            m_acc = 0;
    logic          m_pend = 1'b0;
    logic [DW-1:0] m_wd = '0;
    logic          m_ovf = 1'b0;
    logic [1:0]    ph = 2'd0;

    typedef struct {
        logic [7:0] word;
        logic       nf;
        logic       exp_wen;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[5];

    spi_s2p #(.DATAWIDTH(DW), .SAMPLE_PHASE(2'b01)) dut (
        .clk(clk), .rst(rst), .s2p_enable(s2p_enable), .cnt(cnt), .data_in(data_in),
        .wdata0(wdata0), .wen0(wen0), .not_full0(not_full0), .byte_done(byte_done),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // bit order on the wire that yields the given word in this build
    function automatic logic [7:0] wire_seq(input logic [7:0] w);
`ifdef SPI_S2P_LSB_FIRST_EN
        return rev8(w);
`else
        return w;
`endif
    endfunction

    task automatic settle();
        #1;
        chk("model_wen0", wen0, m_pend & not_full0);
        chk("model_byte_done", byte_done, m_pend);
        chk("model_overflow", overflow, m_ovf);
        chk("model_wdata0", wdata0, m_wd);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_run = 0; m_n = 0; m_acc = 0; m_pend = 0; m_wd = '0; m_ovf = 0;
        end else begin
            if (m_pend && !not_full0) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            if (!s2p_enable) begin
                m_run = 0; m_n = 0; m_acc = 0; m_pend = 0;
            end else if (!m_run) begin
                m_run = 1; m_pend = 0;
            end else begin
                m_pend = 0;
                if (cnt == 2'b01) begin
`ifdef SPI_S2P_LSB_FIRST_EN
                    m_acc = m_acc + (int'(data_in) << m_n);
`else
                    m_acc = m_acc * 2 + int'(data_in);
`endif
                    m_n++;
                    if (m_n == DW) begin
                        m_wd = m_acc[DW-1:0];
                        m_acc = 0; m_n = 0; m_pend = 1;
                    end
                end
            end
        end
        ph = ph + 2'd1;
        @(negedge clk);
    endtask

    task automatic step();
        cnt = ph;
        settle();
        advance();
    endtask

    task automatic enable_at(input logic [1:0] at);
        s2p_enable = 1'b0;
        while (ph != at) step();
        s2p_enable = 1'b1;
        step();
    endtask

    // Streams one word aligned to cnt == 0; the WRITE cycle falls on c == 30.
    task automatic send_word(input logic [7:0] seq, input logic nf, input logic [7:0] exp_w,
                             input logic exp_wen, input logic exp_ovf);
        while (ph != 2'd0) step();
        for (int c = 0; c < 32; c++) begin
            cnt = ph;
            data_in = seq[7 - c / 4];
            not_full0 = (c == 30) ? nf : 1'b1;
            settle();
            if (c == 30) begin
                chk("word_wen0", wen0, exp_wen);
                chk("word_byte_done", byte_done, 1);
                chk("word_wdata0", wdata0, exp_w);
            end
            if (c == 31) begin
                chk("word_overflow", overflow, exp_ovf);
                chk("word_wen0_single", wen0, 0);
                chk("word_byte_done_single", byte_done, 0);
            end
            advance();
        end
        not_full0 = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_lsb_test;
        vecs[0] = '{word: 8'hA5, nf: 1'b1, exp_wen: 1'b1, exp_ovf: 1'b0};
        vecs[1] = '{word: 8'h3C, nf: 1'b1, exp_wen: 1'b1, exp_ovf: 1'b0};
        vecs[2] = '{word: 8'hC3, nf: 1'b1, exp_wen: 1'b1, exp_ovf: 1'b0};
        vecs[3] = '{word: 8'h55, nf: 1'b0, exp_wen: 1'b0, exp_ovf: 1'b1};
        vecs[4] = '{word: 8'h0F, nf: 1'b1, exp_wen: 1'b1, exp_ovf: 1'b1};

        // reset: registers are unknown before the first edge, so that cycle is not compared
        @(negedge clk);
        advance();
        step();
        rst = 1'b0;
        chk("rst_wen0", wen0, 0);
        chk("rst_byte_done", byte_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_wdata0", wdata0, 0);

        enable_at(2'd3);
        for (int i = 0; i < 5; i++)
            send_word(wire_seq(vecs[i].word), vecs[i].nf, vecs[i].word, vecs[i].exp_wen, vecs[i].exp_ovf);

        s2p_enable = 1'b0;
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("ovf_clear", overflow, 0);

        // partial word of 5 bits, then disable
        enable_at(2'd3);
        data_in = 1'b1;
        repeat (20) step();
        s2p_enable = 1'b0;
        repeat (8) begin
            step();
            chk("disable_no_write", wen0, 0);
        end
        enable_at(2'd3);
        send_word(wire_seq(8'h81), 1'b1, 8'h81, 1'b1, 1'b0);

        // partial word of 4 bits, then reset
        data_in = 1'b0;
        repeat (16) step();
        rst = 1'b1;
        s2p_enable = 1'b0;
        step();
        rst = 1'b0;
        chk("midrst_wen0", wen0, 0);
        chk("midrst_byte_done", byte_done, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_wdata0", wdata0, 0);
        enable_at(2'd3);
        send_word(8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // enable rises on a strobe cycle; that strobe must not become a bit
`ifdef SPI_S2P_LSB_FIRST_EN
        exp_lsb_test = 8'h01;
`else
        exp_lsb_test = 8'h80;
`endif
        s2p_enable = 1'b0;
        data_in = 1'b1;
        enable_at(2'd1);
        send_word(8'b1000_0000, 1'b1, exp_lsb_test, 1'b1, 1'b0);

        // randomized traffic, all outputs checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 85) cnt = ph;
            else cnt = 2'($urandom_range(3));
            ph = cnt;
            data_in = 1'($urandom_range(1));
            not_full0 = ($urandom_range(99) < 75);
            overflow_clr = ($urandom_range(99) < 3);
            if ($urandom_range(199) == 0) s2p_enable = ~s2p_enable;
            rst = ($urandom_range(499) == 0);
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_s2p.md
Name: spi_s2p

Overview:
- Serial-to-parallel receive path of the SPI block; the receive-side counterpart of the transmit shifter.
- Samples the serial input line on the shared 2-bit SPI phase counter and assembles DATAWIDTH-bit words, MSB first by default.
- Pushes each completed word into the RX FIFO write port with a one-cycle write strobe.
- Reports dropped words (FIFO full) through a sticky overflow flag.

Parameters:
- DATAWIDTH, 8, word width in bits; legal range 2..32.
- SAMPLE_PHASE, 2'b01, value of cnt on which data_in is sampled.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- s2p_enable  input  1  receive enable; level-sensitive.
- cnt  input  2  SPI phase counter shared with the transmitter.
- data_in  input  1  serial receive data.
- wdata0  output  DATAWIDTH  RX FIFO write data.
- wen0  output  1  RX FIFO write strobe, one cycle per word.
- not_full0  input  1  RX FIFO has space.
- byte_done  output  1  one-cycle pulse per completed word, whether written or dropped.
- overflow  output  1  sticky; set when a completed word is dropped.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - state = IDLE; shift register, bit counter and wdata0 = 0.
  - wen0, byte_done and overflow = 0.
  - Reset asserted mid-word discards the partial word; no write occurs.
- Sample strobe: asserted in a cycle when cnt == SAMPLE_PHASE.
- Bit counter: ceil(log2(DATAWIDTH)) bits wide; counts 0..DATAWIDTH-1, then wraps to 0.
- IDLE:
  - Shift register and bit counter are held at 0.
  - s2p_enable=1 moves to SHIFT on the next edge.
  - A sample strobe in the same cycle as the IDLE-to-SHIFT transition is ignored.
- SHIFT:
  - On each sample strobe: shreg <= {shreg[DATAWIDTH-2:0], data_in} and the bit counter increments.
  - On the sample with bit counter == DATAWIDTH-1:
    - wdata0 is registered with {shreg[DATAWIDTH-2:0], data_in}.
    - The bit counter wraps to 0.
    - Next state is WRITE.
  - s2p_enable=0 returns to IDLE on the next edge; the partial word is discarded and no write occurs.
- WRITE (one cycle):
  - byte_done=1.
  - If not_full0=1: wen0=1 and wdata0 holds the completed word.
  - If not_full0=0: wen0=0, the word is dropped and overflow is set at the next edge.
  - Next state is SHIFT if s2p_enable=1, else IDLE.
  - A sample strobe occurring in WRITE is captured as the first bit of the next word.
  - s2p_enable falling in WRITE does not cancel the write.
- Latency: wen0 is asserted exactly one cycle after the edge that samples the last bit.
- wdata0 holds its value until the next completed word.
- overflow:
  - Set in the cycle after a drop; held until overflow_clr=1 or rst.
  - If a drop and overflow_clr=1 occur in the same cycle, set wins.
- wen0 and byte_done are never high for more than one consecutive cycle.
- Inputs are not sampled in the reset cycle.

Optional Feature:
- Macro: SPI_S2P_LSB_FIRST_EN.
- Defined:
  - Words are assembled LSB first: shreg <= {data_in, shreg[DATAWIDTH-1:1]}.
  - The completed word is {data_in, shreg[DATAWIDTH-1:1]}.
  - Timing, handshakes and the overflow function are unchanged.
- Not defined: MSB-first behaviour as above.

Test Plan:
- Basic receive:
  - Stimulus: rst for 2 cycles, then s2p_enable=1, cnt free-running 00,01,10,11, not_full0=1; data_in bits 1,0,1,0,0,1,0,1 presented at each cnt==01.
  - Response: wen0 high for exactly one cycle, one cycle after the 8th sample; wdata0=8'hA5; byte_done pulses with it.
- Back-to-back words:
  - Stimulus: 8'h3C then 8'hC3 streamed continuously.
  - Response: two wen0 pulses spaced 32 cycles apart, carrying 8'h3C then 8'hC3; no lost bits; overflow=0.
- FIFO full drop and clear:
  - Stimulus: not_full0=0 during the WRITE cycle of word 8'h55.
  - Response: wen0 stays 0; byte_done=1; overflow=1 on the next cycle and stays high.
  - Stimulus: pulse overflow_clr for 1 cycle.
  - Response: overflow=0.
- Mid-word disable:
  - Stimulus: drop s2p_enable after 5 bits, re-enable, then send 8'h81.
  - Response: no write for the partial word; next write is wdata0=8'h81.
- Mid-word reset:
  - Stimulus: assert rst for 1 cycle after 4 bits, then send 8'hFF.
  - Response: all outputs 0 in the cycle after rst; the partial word is never written; next write is 8'hFF.
- LSB-first build:
  - Stimulus: with SPI_S2P_LSB_FIRST_EN defined, send bits 1,0,0,0,0,0,0,0.
  - Response: wdata0=8'h01.
  - Stimulus: same bits without the macro.
  - Response: wdata0=8'h80.
